regfile_wb_ctrl: RTL and testbench
==================================

// Module: regfile_wb_ctrl
// PURPOSE
//   Write-side controller for the 32x32 register file (x0 hardwired zero, async read, sync write).
//   Merges two result sources onto the single write port:
//   - in-order pipeline writeback;
//   - out-of-order results from the multi-cycle maths accelerator, buffered in a FIFO.
//   Keeps a per-register pending scoreboard so decode can stall on RAW/WAW against in-flight accelerator ops.
// PARAMETERS
//   FIFO_DEPTH    4   accelerator result FIFO entries (power of 2, >=2)
//   STARVE_LIMIT  8   consecutive cycles FIFO head may lose arbitration before wb_hold (>=1)
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   pipe_we    in   1   pipeline writeback valid (no backpressure, always accepted)
//   pipe_rd    in   5   pipeline destination register
//   pipe_wd    in   32  pipeline write data
//   iss_valid  in   1   accelerator op issued this cycle
//   iss_rd     in   5   destination of issued accelerator op
//   acc_valid  in   1   accelerator result valid
//   acc_ready  out  1   FIFO can accept a result
//   acc_rd     in   5   accelerator result destination
//   acc_wd     in   32  accelerator result data
//   haz_rs1    in   5   decode source 1 for hazard check
//   haz_rs2    in   5   decode source 2 for hazard check
//   haz_rd     in   5   decode destination for hazard check
//   stall      out  1   decode must stall (pending hazard)
//   wb_hold    out  1   pipeline must not present pipe_we this cycle
//   rf_we      out  1   register file write enable
//   rf_waddr   out  5   register file write address
//   rf_wdata   out  32  register file write data
//   fwd1_valid out  1   rf write this cycle targets haz_rs1
//   fwd1_data  out  32  forwarded value for haz_rs1
//   fwd2_valid out  1   rf write this cycle targets haz_rs2
//   fwd2_data  out  32  forwarded value for haz_rs2
// BEHAVIOUR
//   Reset:
//   - rf_we/rf_waddr/rf_wdata = 0, wb_hold = 0, acc_ready = 0, fwd*_valid = 0.
//   - FIFO emptied, pending[31:0] cleared, starve counter cleared.
//   - rst mid-operation discards FIFO contents and pending bits with no write.
//   Arbitration (cycle N, result registered to rf_* for cycle N+1):
//   - pipe_we && pipe_rd != 0 wins.
//   - Otherwise, if the FIFO is non-empty, pop the head.
//   - Otherwise rf_we = 0 next cycle.
//   - pipe_we with pipe_rd == 0 is ignored and does not block the FIFO.
//   - Popped entry with rd == 0: dropped, rf_we = 0.
//   Latency:
//   - Pipeline: 1 cycle.
//   - Accelerator: push at edge N+1 after handshake in N; earliest rf_we in N+2.
//   FIFO:
//   - acc_ready = (count < FIFO_DEPTH), computed from registered count; a same-cycle pop does not raise it.
//   - Push on acc_valid && acc_ready. Pointers wrap modulo FIFO_DEPTH.
//   - Simultaneous push and pop: count unchanged.
//   Scoreboard:
//   - iss_valid && iss_rd != 0 sets pending[iss_rd].
//   - Pop of an entry clears pending[rd].
//   - Set and clear of the same bit in one cycle: set wins.
//   - stall = OR over x in {haz_rs1, haz_rs2, haz_rd}, x != 0, of pending[x].
//   - stall is combinational, same cycle.
//   - Protocol: iss_rd is never already pending, and pipe_rd is never pending (guaranteed by stall); bench asserts both.
//   Starvation:
//   - Counter increments when the FIFO is non-empty and the pipe wins; resets on pop or when the FIFO is empty.
//   - When counter == STARVE_LIMIT, wb_hold = 1 for exactly the next cycle.
//   - During wb_hold the FIFO head pops unconditionally and the counter resets.
//   - pipe_we while wb_hold = 1 is a protocol error (asserted in bench).
// CONFIGURATION
//   WB_FWD_EN defined:
//   - fwdN_valid = rf_we && rf_waddr == haz_rsN && haz_rsN != 0.
//   - fwdN_data = rf_wdata.
//   - Covers a read of a register in the same cycle as its write.
//   WB_FWD_EN undefined:
//   - fwd*_valid tied 0, fwd*_data tied 0; decode reads the register file a cycle later.
// TESTING
//   1. Reset: rst = 1 for 2 cycles with acc_valid = 1 -> acc_ready = 0, rf_we = 0; after release acc_ready = 1, stall = 0.
//   2. pipe_we = 1, rd = 5, wd = 0xDEAD_BEEF -> next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEAD_BEEF; rd = 0 -> rf_we = 0.
//   3. iss rd = 7; haz_rs1 = 7 -> stall = 1; acc result (7, 0x1234) pushed -> rf write 0x1234 two cycles later; stall drops after the pop edge.
//   4. Fill FIFO with 4 results while pipe_we is held high -> acc_ready = 0 at count 4; after 8 starved cycles wb_hold = 1 for one cycle and one entry pops.
//   5. Same-cycle iss rd = 3 and pop of rd = 3 -> pending[3] stays 1; push and pop together at count 2 -> count stays 2.
//   6. WB_FWD_EN: rf write (9, 0xAA55) with haz_rs2 = 9 -> fwd2_valid = 1, fwd2_data = 0xAA55; without the macro -> fwd2_valid = 0.

Source files
------------

// File: rtl/regfile_wb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_ctrl_if
// Purpose  : Bundles the writeback, accelerator, hazard-check and register
//            file write signals of regfile_wb_ctrl.
//            master : pipeline / decode / accelerator side
//            slave  : the write-side controller
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_ctrl_if;
    // pipeline writeback
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    // accelerator issue and result
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        acc_valid;
    logic        acc_ready;
    logic [4:0]  acc_rd;
    logic [31:0] acc_wd;
    // decode hazard check
    logic [4:0]  haz_rs1;
    logic [4:0]  haz_rs2;
    logic [4:0]  haz_rd;
    logic        stall;
    logic        wb_hold;
    // register file write port and forwarding
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd1_valid;
    logic [31:0] fwd1_data;
    logic        fwd2_valid;
    logic [31:0] fwd2_data;

    modport master (
        output pipe_we, pipe_rd, pipe_wd,
        output iss_valid, iss_rd,
        output acc_valid, acc_rd, acc_wd,
        output haz_rs1, haz_rs2, haz_rd,
        input  acc_ready, stall, wb_hold,
        input  rf_we, rf_waddr, rf_wdata,
        input  fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_wd,
        input  iss_valid, iss_rd,
        input  acc_valid, acc_rd, acc_wd,
        input  haz_rs1, haz_rs2, haz_rd,
        output acc_ready, stall, wb_hold,
        output rf_we, rf_waddr, rf_wdata,
        output fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_ctrl
// Purpose  : Write-side controller for the 32x32 register file. Merges the
//            in-order pipeline writeback and the out-of-order accelerator
//            results (buffered in a FIFO) onto the single write port, and
//            keeps a per-register pending scoreboard for decode stalls.
// Ports    : clk, rst (sync, active-high)
//            bus (regfile_wb_ctrl_if.slave):
//              pipe_we/rd/wd      pipeline writeback (always accepted)
//              iss_valid/rd       accelerator op issue (sets pending)
//              acc_valid/ready/rd/wd  accelerator result into FIFO
//              haz_rs1/rs2/rd, stall   decode hazard check (combinational)
//              wb_hold            pipeline must not write this cycle
//              rf_we/waddr/wdata  registered register file write
//              fwd1/2_valid/data  same-cycle forwarding of the rf write
// Config   : define WB_FWD_EN to enable the forwarding outputs; otherwise
//            they are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    regfile_wb_ctrl_if.slave bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    // FIFO storage (data only, no reset needed)
    logic [4:0]  fifo_rd_q [FIFO_DEPTH];
    logic [31:0] fifo_wd_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pending_q, pending_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             wb_hold_q;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;

    logic        empty_w;
    logic        acc_ready_w;
    logic        push_w;
    logic        pipe_win_w;
    logic        pop_w;
    logic [4:0]  head_rd_w;
    logic [31:0] head_wd_w;

    assign empty_w     = (count_q == '0);
    // Ready comes from the registered count only, so a pop in the same
    // cycle never lets a push into a full FIFO.
    assign acc_ready_w = !rst && (count_q < CNT_W'(FIFO_DEPTH));
    assign push_w      = bus.acc_valid && acc_ready_w;
    // While wb_hold is up the FIFO owns the write port regardless of pipe_we.
    assign pipe_win_w  = bus.pipe_we && (bus.pipe_rd != 5'd0) && !wb_hold_q;
    assign pop_w       = !empty_w && (wb_hold_q || !pipe_win_w);
    assign head_rd_w   = fifo_rd_q[rd_ptr_q];
    assign head_wd_w   = fifo_wd_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear first, then set, so an issue to the register being retired
    // this cycle keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (pop_w)
            pending_d[head_rd_w] = 1'b0;
        if (bus.iss_valid && (bus.iss_rd != 5'd0))
            pending_d[bus.iss_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        starve_d = starve_q;
        if (empty_w || pop_w)
            starve_d = '0;
        else if (pipe_win_w)
            starve_d = starve_q + STV_W'(1);
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = 5'd0;
        rf_wdata_d = 32'd0;
        if (pipe_win_w) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.pipe_rd;
            rf_wdata_d = bus.pipe_wd;
        end else if (pop_w && (head_rd_w != 5'd0)) begin
            // x0 results are popped but never written
            rf_we_d    = 1'b1;
            rf_waddr_d = head_rd_w;
            rf_wdata_d = head_wd_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            starve_q   <= '0;
            wb_hold_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            if (push_w)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_w)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_d;
            pending_q  <= pending_d;
            starve_q   <= starve_d;
            // The counter reaching the limit forces exactly one hold cycle;
            // the pop during that cycle returns the counter to zero.
            wb_hold_q  <= (starve_d == STV_W'(STARVE_LIMIT));
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_w) begin
            fifo_rd_q[wr_ptr_q] <= bus.acc_rd;
            fifo_wd_q[wr_ptr_q] <= bus.acc_wd;
        end
    end

    assign bus.acc_ready = acc_ready_w;
    assign bus.wb_hold   = wb_hold_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.stall     = ((bus.haz_rs1 != 5'd0) && pending_q[bus.haz_rs1]) ||
                           ((bus.haz_rs2 != 5'd0) && pending_q[bus.haz_rs2]) ||
                           ((bus.haz_rd  != 5'd0) && pending_q[bus.haz_rd]);

`ifdef WB_FWD_EN
    assign bus.fwd1_valid = rf_we_q && (rf_waddr_q == bus.haz_rs1) && (bus.haz_rs1 != 5'd0);
    assign bus.fwd1_data  = rf_wdata_q;
    assign bus.fwd2_valid = rf_we_q && (rf_waddr_q == bus.haz_rs2) && (bus.haz_rs2 != 5'd0);
    assign bus.fwd2_data  = rf_wdata_q;
`else
    assign bus.fwd1_valid = 1'b0;
    assign bus.fwd1_data  = 32'd0;
    assign bus.fwd2_valid = 1'b0;
    assign bus.fwd2_data  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_ctrl
// Purpose  : Directed self-checking bench for regfile_wb_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_wb_ctrl;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    regfile_wb_ctrl_if bus ();

    regfile_wb_ctrl #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Protocol checks, sampled mid-cycle when inputs are stable.
    always @(negedge clk) begin
        if (!rst && bus.wb_hold && bus.pipe_we) begin
            fails++;
            $display("FAIL proto_hold: pipe_we=1 while wb_hold=1 (required pipe_we=0)");
        end
        if (!rst && bus.pipe_we && bus.pipe_rd != 5'd0 && dut.pending_q[bus.pipe_rd]) begin
            fails++;
            $display("FAIL proto_pipe_rd: pipe_rd=%0d is pending (required not pending)", bus.pipe_rd);
        end
        if (!rst && bus.iss_valid && bus.iss_rd != 5'd0 && dut.pending_q[bus.iss_rd] &&
            !(dut.pop_w && dut.head_rd_w == bus.iss_rd)) begin
            fails++;
            $display("FAIL proto_iss_rd: iss_rd=%0d already pending (required not pending)", bus.iss_rd);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (required finish)");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipe_we   = 1'b0; bus.pipe_rd = 5'd0; bus.pipe_wd = 32'd0;
        bus.iss_valid = 1'b0; bus.iss_rd  = 5'd0;
        bus.acc_valid = 1'b0; bus.acc_rd  = 5'd0; bus.acc_wd  = 32'd0;
        bus.haz_rs1   = 5'd0; bus.haz_rs2 = 5'd0; bus.haz_rd  = 5'd0;
    endtask

    task automatic issue(input logic [4:0] rd);
        tick(); idle();
        bus.iss_valid = 1'b1; bus.iss_rd = rd;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        bus.acc_valid = 1'b1; bus.acc_rd = 5'd4; bus.acc_wd = 32'h4444;
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            tests++;
            if ({bus.acc_ready, bus.rf_we} !== 2'b00) begin
                fails++;
                $display("FAIL reset_hold: acc_ready,rf_we=%b required 00", {bus.acc_ready, bus.rf_we});
            end
        end
        tick();
        rst = 1'b0; idle(); #1;
        tests++;
        if ({bus.acc_ready, bus.stall, bus.wb_hold, bus.rf_we, bus.fwd1_valid, bus.fwd2_valid} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_release: ready,stall,hold,we,f1,f2=%b required 100000",
                     {bus.acc_ready, bus.stall, bus.wb_hold, bus.rf_we, bus.fwd1_valid, bus.fwd2_valid});
        end
        tests++;
        if ({bus.rf_waddr, bus.rf_wdata} !== 37'd0) begin
            fails++;
            $display("FAIL reset_rf: waddr=%0d wdata=%h required 0/0", bus.rf_waddr, bus.rf_wdata);
        end
    endtask

    task automatic test_pipe();
        tick(); idle();
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_wd = 32'hDEAD_BEEF;
        tick(); idle();
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd0; bus.pipe_wd = 32'h1111_1111; #1;
        tests++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            fails++;
            $display("FAIL pipe_write: we=%b addr=%0d data=%h required 1/5/deadbeef",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        tick(); idle(); #1;
        tests++;
        if (bus.rf_we !== 1'b0) begin
            fails++;
            $display("FAIL pipe_x0: rf_we=%b required 0", bus.rf_we);
        end
    endtask

    task automatic test_acc_path();
        issue(5'd7);
        tick(); idle();
        bus.haz_rs1 = 5'd7;
        bus.acc_valid = 1'b1; bus.acc_rd = 5'd7; bus.acc_wd = 32'h1234; #1;
        tests++;
        if (bus.stall !== 1'b1) begin
            fails++;
            $display("FAIL acc_stall_set: stall=%b required 1", bus.stall);
        end
        // pipe_we to x0 must not block the pop
        tick(); idle();
        bus.haz_rs1 = 5'd7; bus.pipe_we = 1'b1; bus.pipe_rd = 5'd0; #1;
        tests++;
        if ({bus.stall, bus.rf_we} !== 2'b10) begin
            fails++;
            $display("FAIL acc_pop_cycle: stall,rf_we=%b required 10", {bus.stall, bus.rf_we});
        end
        tick(); idle();
        bus.haz_rs1 = 5'd7; #1;
        tests++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall} !== {1'b1, 5'd7, 32'h1234, 1'b0}) begin
            fails++;
            $display("FAIL acc_write: we=%b addr=%0d data=%h stall=%b required 1/7/1234/0",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall);
        end
    endtask

    task automatic test_starve();
        int hold_k;
        logic ready_ok;
        for (int i = 0; i < 4; i++) issue(5'(10 + i));
        ready_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); idle();
            bus.pipe_we = 1'b1; bus.pipe_rd = 5'd1; bus.pipe_wd = 32'(i);
            bus.acc_valid = 1'b1; bus.acc_rd = 5'(10 + i); bus.acc_wd = 32'hA000 + 32'(i);
            #1;
            if (bus.acc_ready !== 1'b1) ready_ok = 1'b0;
        end
        tests++;
        if (ready_ok !== 1'b1) begin
            fails++;
            $display("FAIL fill_ready: acc_ready dropped during fill, required 1");
        end
        hold_k = 20;
        for (int k = 0; k < 20; k++) begin
            tick(); idle();
            if (bus.wb_hold === 1'b1) begin
                hold_k = k;
                break;
            end
            bus.pipe_we = 1'b1; bus.pipe_rd = 5'd1; bus.pipe_wd = 32'h100 + 32'(k);
            if (k == 0) begin
                #1;
                tests++;
                if (bus.acc_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL full_ready: acc_ready=%b required 0", bus.acc_ready);
                end
            end
        end
        tests++;
        if (hold_k != 5) begin
            fails++;
            $display("FAIL starve_hold: hold after %0d extra cycles, required 5", hold_k);
        end
        tick(); idle(); #1;
        tests++;
        if ({bus.wb_hold, bus.acc_ready, bus.rf_we, bus.rf_waddr, bus.rf_wdata} !==
            {1'b0, 1'b1, 1'b1, 5'd10, 32'hA000}) begin
            fails++;
            $display("FAIL hold_pop: hold=%b ready=%b we=%b addr=%0d data=%h required 0/1/1/10/a000",
                     bus.wb_hold, bus.acc_ready, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        for (int i = 1; i < 4; i++) begin
            tick(); idle(); #1;
            tests++;
            if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'(10 + i), 32'hA000 + 32'(i)}) begin
                fails++;
                $display("FAIL drain_%0d: we=%b addr=%0d data=%h required 1/%0d/%h",
                         i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, 10 + i, 32'hA000 + 32'(i));
            end
        end
        tick(); idle();
        bus.haz_rd = 5'd13; #1;
        tests++;
        if ({bus.rf_we, bus.stall} !== 2'b00) begin
            fails++;
            $display("FAIL drain_empty: we,stall=%b required 00", {bus.rf_we, bus.stall});
        end
    endtask

    task automatic test_set_clear();
        issue(5'd3);
        tick(); idle();
        bus.acc_valid = 1'b1; bus.acc_rd = 5'd3; bus.acc_wd = 32'h33;
        // pop of rd 3 coincides with a new issue to rd 3
        tick(); idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
        tick(); idle();
        bus.haz_rs1 = 5'd3; #1;
        tests++;
        if ({bus.stall, bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 1'b1, 5'd3, 32'h33}) begin
            fails++;
            $display("FAIL set_wins: stall=%b we=%b addr=%0d data=%h required 1/1/3/33",
                     bus.stall, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        tick(); idle();
        bus.acc_valid = 1'b1; bus.acc_rd = 5'd3; bus.acc_wd = 32'h44;
        tick(); idle();
        tick(); idle();
        bus.haz_rs1 = 5'd3; #1;
        tests++;
        if ({bus.stall, bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 1'b1, 5'd3, 32'h44}) begin
            fails++;
            $display("FAIL set_clear_done: stall=%b we=%b addr=%0d data=%h required 0/1/3/44",
                     bus.stall, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) issue(5'(20 + i));
        for (int i = 0; i < 2; i++) begin
            tick(); idle();
            bus.pipe_we = 1'b1; bus.pipe_rd = 5'd1; bus.pipe_wd = 32'hB0 + 32'(i);
            bus.acc_valid = 1'b1; bus.acc_rd = 5'(20 + i); bus.acc_wd = 32'hC0 + 32'(i);
        end
        // push and pop together at count 2
        tick(); idle();
        bus.acc_valid = 1'b1; bus.acc_rd = 5'd22; bus.acc_wd = 32'hC2; #1;
        tests++;
        if ({bus.acc_ready, bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 1'b1, 5'd1, 32'hB1}) begin
            fails++;
            $display("FAIL b2b_pipe: ready=%b we=%b addr=%0d data=%h required 1/1/1/b1",
                     bus.acc_ready, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); #1;
            tests++;
            if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'(20 + i), 32'hC0 + 32'(i)}) begin
                fails++;
                $display("FAIL b2b_pop_%0d: we=%b addr=%0d data=%h required 1/%0d/%h",
                         i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, 20 + i, 32'hC0 + 32'(i));
            end
        end
        tick(); idle(); #1;
        tests++;
        if (bus.rf_we !== 1'b0) begin
            fails++;
            $display("FAIL b2b_count: extra write rf_we=%b addr=%0d, required 0", bus.rf_we, bus.rf_waddr);
        end
    endtask

    task automatic test_x0_drop();
        tick(); idle();
        bus.acc_valid = 1'b1; bus.acc_rd = 5'd0; bus.acc_wd = 32'h99;
        tick(); idle();
        tick(); idle(); #1;
        tests++;
        if (bus.rf_we !== 1'b0) begin
            fails++;
            $display("FAIL x0_drop: rf_we=%b required 0", bus.rf_we);
        end
    endtask

    task automatic test_reset_mid();
        issue(5'd15);
        tick(); idle();
        bus.acc_valid = 1'b1; bus.acc_rd = 5'd15; bus.acc_wd = 32'hF0F0;
        tick(); idle();
        rst = 1'b1;
        tick(); idle();
        rst = 1'b0;
        bus.haz_rs1 = 5'd15; #1;
        tests++;
        if ({bus.rf_we, bus.stall, bus.acc_ready} !== 3'b001) begin
            fails++;
            $display("FAIL mid_reset: we,stall,ready=%b required 001", {bus.rf_we, bus.stall, bus.acc_ready});
        end
        tick(); idle(); #1;
        tests++;
        if (bus.rf_we !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_fifo: rf_we=%b required 0", bus.rf_we);
        end
    endtask

    task automatic test_forward();
        logic        exp_v;
        logic [31:0] exp_d;
        exp_v = FWD;
        exp_d = FWD ? 32'hAA55 : 32'd0;
        tick(); idle();
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd9; bus.pipe_wd = 32'hAA55;
        tick(); idle();
        bus.haz_rs1 = 5'd9; bus.haz_rs2 = 5'd9; #1;
        tests++;
        if ({bus.fwd2_valid, bus.fwd2_data} !== {exp_v, exp_d}) begin
            fails++;
            $display("FAIL fwd2: valid=%b data=%h required %b/%h", bus.fwd2_valid, bus.fwd2_data, exp_v, exp_d);
        end
        tests++;
        if ({bus.fwd1_valid, bus.fwd1_data} !== {exp_v, exp_d}) begin
            fails++;
            $display("FAIL fwd1: valid=%b data=%h required %b/%h", bus.fwd1_valid, bus.fwd1_data, exp_v, exp_d);
        end
        bus.haz_rs2 = 5'd8; #1;
        tests++;
        if ({bus.fwd2_valid, bus.fwd1_valid} !== {1'b0, exp_v}) begin
            fails++;
            $display("FAIL fwd_miss: fwd2_valid=%b fwd1_valid=%b required 0/%b",
                     bus.fwd2_valid, bus.fwd1_valid, exp_v);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_pipe();
        test_acc_path();
        test_starve();
        test_set_clear();
        test_back_to_back();
        test_x0_drop();
        test_reset_mid();
        test_forward();
        tick(); idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
